// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one byte (start, 5-8 data bits, optional parity, 1-2 stops)
// onto txd, paced by an oversampled baud tick, with a valid/ready handshake to the host.

module parity_gen (
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       eps,
    output logic       parity
);
    logic [7:0] mask;

    // Only the 5+wls low bits take part; eps=1 makes data+parity even, eps=0 makes it odd.
    always_comb begin
        mask   = 8'hFF >> (2'd3 - wls);
        parity = (^(data & mask)) ^ ~eps;
    end
endmodule

module uart_tx_ctrl #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       STB,
    input  logic       BC,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] sh_data;
    logic [1:0] sh_wls;
    logic       sh_pen;
    logic       sh_eps;
    logic       sh_stb;
    logic       done_reg;
    logic       line;
    logic       parity;
    logic       transfer;
    logic       bit_end;
    logic       last_data;
    logic       last_stop;

    assign transfer  = tx_valid && tx_ready;
    assign bit_end   = baud_tick && (tick_cnt == 4'(OVERSAMPLE - 1));
    assign last_data = (bit_cnt == ({1'b0, sh_wls} + 3'd4));
    assign last_stop = (bit_cnt == {2'b00, sh_stb});

    parity_gen u_parity (
        .data   (sh_data),
        .wls    (sh_wls),
        .eps    (sh_eps),
        .parity (parity)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (transfer) next_state = START;
            START:   if (bit_end) next_state = DATA;
            DATA:    if (bit_end && last_data) next_state = sh_pen ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end && last_stop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = 1'b0;
        tx_busy  = 1'b1;
        line     = 1'b1;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
            end
            START:   line = 1'b0;
            DATA:    line = sh_data[bit_cnt];
            PARITY:  line = parity;
            STOP:    line = 1'b1;
            default: line = 1'b1;
        endcase
    end

    // Counters sit at zero in IDLE, so the tick on the accepting edge never counts.
    // bit_cnt restarts whenever the state changes and advances while a state repeats bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
        end else if (state == IDLE) begin
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
        end else if (baud_tick) begin
            tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;
            if (bit_end) begin
                bit_cnt <= (next_state == state) ? bit_cnt + 3'd1 : 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data <= 8'd0;
            sh_wls  <= 2'd0;
            sh_pen  <= 1'b0;
            sh_eps  <= 1'b0;
            sh_stb  <= 1'b0;
        end else if (transfer) begin
            sh_data <= tx_data;
            sh_wls  <= WLS;
            sh_pen  <= PEN;
            sh_eps  <= EPS;
            sh_stb  <= STB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state == STOP) && (next_state == IDLE);
        end
    end

    assign tx_done = done_reg;
    assign txd     = line & ~BC;
endmodule
